// File: rtl/float_pkg.sv
// Shared single-precision float definitions used by the float conversion blocks.
package float_pkg;

  localparam int FLT_EXP_W  = 8;
  localparam int FLT_FRAC_W = 23;
  localparam int FLT_BIAS   = 127;

  typedef struct packed {
    logic                  sign;
    logic [FLT_EXP_W-1:0]  exp;
    logic [FLT_FRAC_W-1:0] frac;
  } float32_t;

endpackage

// File: rtl/float_rne_round.sv
// Round-to-nearest, ties-to-even on an unsigned magnitude.
// The guard bit carries weight one half of the magnitude LSB. Round and sticky
// together say whether anything lies below that half.
// The result is one bit wider than the input so that a carry out is never lost.
module float_rne_round #(
  parameter int W = 16
) (
  input  logic [W-1:0] mag,
  input  logic         guard,
  input  logic         round,
  input  logic         sticky,
  output logic [W:0]   rounded
);

  logic inc;

  // Round up above the half. On an exact half, round up only when that makes the result even.
  assign inc     = guard & (round | sticky | mag[0]);
  assign rounded = {1'b0, mag} + {{W{1'b0}}, inc};

endmodule

// File: rtl/float_to_int_nb.sv
// IEEE 754 single to signed OUT_W-bit integer converter.
// The block is a three-stage pipeline that uses round-to-nearest-even.
// Optional feature macro: FLOAT_TO_INT_EXC_EN. It adds the dout_exc port.
// It also gives NaN and Inf their own handling.
//
// Handshake: din_valid qualifies din on every rising edge. There is no ready
// signal, so every valid beat is accepted. Each accepted beat produces exactly
// one dout_valid beat three register stages later, and beats stay in order.
// While dout_valid is low, dout (and dout_exc) hold their last value.
module float_to_int_nb
  import float_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid
`ifdef FLOAT_TO_INT_EXC_EN
  ,
  output logic             dout_exc
`endif
);

  // The significand is shifted left by e+1.
  // This leaves FW fraction bits below an integer field of OUT_W bits.
  localparam int FW = FLT_FRAC_W + 1;
  localparam int TW = OUT_W + FW;

  localparam logic [OUT_W:0]   MAX_MAG = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]   MIN_MAG = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAX_INT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_INT = {1'b1, {(OUT_W-1){1'b0}}};

  float32_t f_in;
  assign f_in = din;

  // Stage 1 registers
  logic               s1_valid;
  logic               s1_sign;
  logic [FW-1:0]      s1_sig;
  logic signed [8:0]  s1_e;
`ifdef FLOAT_TO_INT_EXC_EN
  logic               s1_spec;
  logic               s1_nan;
`endif

  // Stage 1: split the fields, restore the hidden bit, and remove the bias.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sig   <= '0;
      s1_e     <= '0;
`ifdef FLOAT_TO_INT_EXC_EN
      s1_spec  <= 1'b0;
      s1_nan   <= 1'b0;
`endif
    end else begin
      s1_valid <= din_valid;
      if (din_valid) begin
        s1_sign <= f_in.sign;
        s1_sig  <= {f_in.exp != '0, f_in.frac};
        s1_e    <= {1'b0, f_in.exp} - 9'(FLT_BIAS);
`ifdef FLOAT_TO_INT_EXC_EN
        s1_spec <= (f_in.exp == '1);
        s1_nan  <= (f_in.exp == '1) && (f_in.frac != '0);
`endif
      end
    end
  end

  // Stage 2 alignment
  logic           too_big;
  logic           too_small;
  logic [8:0]     e_p1;
  logic [TW-1:0]  aligned;
  logic [OUT_W:0] rounded;

  // Anything below 0.5 becomes zero. This also covers denormals, whose e is -127.
  // Values at or above 2^OUT_W saturate without being shifted.
  assign too_big   = (s1_e >= $signed(9'(OUT_W)));
  assign too_small = (s1_e < -9'sd1);
  assign e_p1      = s1_e + 9'sd1;

  // Place the binary point FW bits up. Only in-range exponents are shifted.
  always_comb begin
    aligned = '0;
    if (!too_big && !too_small) begin
      aligned = TW'(s1_sig) << e_p1;
    end
  end

  float_rne_round #(.W(OUT_W)) u_round (
    .mag     (aligned[TW-1:FW]),
    .guard   (aligned[FW-1]),
    .round   (aligned[FW-2]),
    .sticky  (|aligned[FW-3:0]),
    .rounded (rounded)
  );

  // Stage 2 registers
  logic           s2_valid;
  logic           s2_sign;
  logic [OUT_W:0] s2_mag;
`ifdef FLOAT_TO_INT_EXC_EN
  logic           s2_spec;
  logic           s2_nan;
`endif

  // Stage 2: register the rounded magnitude. An all-ones value forces saturation.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mag   <= '0;
`ifdef FLOAT_TO_INT_EXC_EN
      s2_spec  <= 1'b0;
      s2_nan   <= 1'b0;
`endif
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_mag  <= too_big ? '1 : rounded;
`ifdef FLOAT_TO_INT_EXC_EN
        s2_spec <= s1_spec;
        s2_nan  <= s1_nan;
`endif
      end
    end
  end

  // Stage 3 result
  logic [OUT_W-1:0] res;
  logic             sat;

  // Apply the sign and clamp. A magnitude of exactly 2^(OUT_W-1) is a legal negative value.
  // A zero magnitude negates to zero, so -0 cannot occur.
  always_comb begin
    res = '0;
    sat = 1'b0;
    if (!s2_sign) begin
      if (s2_mag > MAX_MAG) begin
        res = MAX_INT;
        sat = 1'b1;
      end else begin
        res = s2_mag[OUT_W-1:0];
      end
    end else begin
      if (s2_mag > MIN_MAG) begin
        res = MIN_INT;
        sat = 1'b1;
      end else begin
        res = (~s2_mag[OUT_W-1:0]) + {{(OUT_W-1){1'b0}}, 1'b1};
      end
    end
`ifdef FLOAT_TO_INT_EXC_EN
    if (s2_nan) begin
      res = '0;
    end
`endif
  end

  // Stage 3: output registers. They update only on valid beats so that the values hold during gaps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
`ifdef FLOAT_TO_INT_EXC_EN
      dout_exc   <= 1'b0;
`endif
    end else begin
      dout_valid <= s2_valid;
      if (s2_valid) begin
        dout     <= res;
`ifdef FLOAT_TO_INT_EXC_EN
        dout_exc <= sat | s2_spec;
`endif
      end
    end
  end

`ifndef FLOAT_TO_INT_EXC_EN
  logic unused_sat;
  assign unused_sat = sat;
`endif

endmodule

// File: tb/tb_float_to_int_nb.sv
// Directed and randomized checks for float_to_int_nb at OUT_W=16.
// The default OUT_W is used. Exception checks apply when FLOAT_TO_INT_EXC_EN is defined.
module tb_float_to_int_nb;

  localparam int OUT_W = 16;
  localparam int W     = OUT_W + 2;   // {valid, exc, data}

`ifdef FLOAT_TO_INT_EXC_EN
  localparam logic [15:0] NAN_OUT = 16'h0000;
`else
  localparam logic [15:0] NAN_OUT = 16'h7FFF;
`endif

  logic             clk = 1'b0;
  logic             nrst;
  logic [31:0]      din;
  logic             din_valid;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_exc;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [15:0]  last_dout;

  float_to_int_nb #(.OUT_W(OUT_W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
`ifdef FLOAT_TO_INT_EXC_EN
    ,
    .dout_exc   (dout_exc)
`endif
  );

`ifndef FLOAT_TO_INT_EXC_EN
  assign dout_exc = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model for the random stream.
  // It compares the dropped fraction against one half. It returns {exc, data}.
  function automatic logic [16:0] ref_conv(input logic [31:0] f);
    int          ex;
    longint      sig, x, ip, rem;
    logic        exc;
    logic [15:0] r;
    ex  = int'(f[30:23]);
    sig = longint'({1'b1, f[22:0]});
    exc = 1'b0;
    ip  = 0;
    if (ex == 255) begin
`ifdef FLOAT_TO_INT_EXC_EN
      if (f[22:0] != 23'd0) return {1'b1, 16'h0000};
`endif
      ip = 64'd1 << 20;
    end else if (ex == 0) begin
      ip = 0;
    end else if (ex - 127 >= 16) begin
      ip = 64'd1 << 20;
    end else if (ex - 127 >= -1) begin
      x   = sig << (ex - 126);
      ip  = x >> 24;
      rem = x & 64'hFFFFFF;
      if (rem > 64'h800000 || (rem == 64'h800000 && ip[0])) ip = ip + 1;
    end
    if (!f[31]) begin
      if (ip > 32767) begin r = 16'h7FFF; exc = 1'b1; end
      else r = 16'(ip);
    end else begin
      if (ip > 32768) begin r = 16'h8000; exc = 1'b1; end
      else r = 16'(-ip);
    end
    if (ex == 255) exc = 1'b1;
    return {exc, r};
  endfunction

  // ---------------- driver ----------------
  // Each step presents one beat at a negedge and pushes its expectation.
  // It then compares the beat that was accepted three edges earlier.
  task automatic step(input logic v, input logic [31:0] d, input logic [15:0] e_dout,
                      input logic e_exc, input string tag);
    logic [W-1:0] ent;
    string        t;
    din       = d;
    din_valid = v;
    exp_q.push_back({v, e_exc, e_dout});
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() >= 3) begin
      ent = exp_q.pop_front();
      t   = tag_q.pop_front();
      if (ent[W-1]) begin
        check({t, "_valid"}, 32'(dout_valid), 32'd1);
        check({t, "_dout"}, 32'(dout), 32'(ent[15:0]));
`ifdef FLOAT_TO_INT_EXC_EN
        check({t, "_exc"}, 32'(dout_exc), 32'(ent[16]));
`endif
        last_dout = ent[15:0];
      end else begin
        check({t, "_novalid"}, 32'(dout_valid), 32'd0);
        check({t, "_hold"}, 32'(dout), 32'(last_dout));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] f;
    logic [16:0] r;
    int          n;
    nrst      = 1'b0;
    din       = 32'h0;
    din_valid = 1'b0;
    last_dout = 16'h0;
    #1;
    check("reset_valid", 32'(dout_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
`ifdef FLOAT_TO_INT_EXC_EN
    check("reset_exc", 32'(dout_exc), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;

    // Directed vectors: ties, small values, saturation, and the exact minimum.
    step(1'b1, 32'h3FC00000, 16'h0002, 1'b0, "p1_5");
    step(1'b1, 32'h40200000, 16'h0002, 1'b0, "p2_5");
    step(1'b1, 32'h40600000, 16'h0004, 1'b0, "p3_5");
    step(1'b0, 32'h12345678, 16'h0000, 1'b0, "gap1");
    step(1'b1, 32'h3F000000, 16'h0000, 1'b0, "p0_5");
    step(1'b1, 32'hBF000000, 16'h0000, 1'b0, "m0_5");
    step(1'b1, 32'h00400000, 16'h0000, 1'b0, "denorm");
    step(1'b1, 32'h80400000, 16'h0000, 1'b0, "neg_denorm");
    step(1'b1, 32'h471C4000, 16'h7FFF, 1'b1, "p40000");
    step(1'b1, 32'hC7000000, 16'h8000, 1'b0, "m32768");
    step(1'b1, 32'hC9742400, 16'h8000, 1'b1, "m1e6");
    step(1'b0, 32'h3FC00000, 16'h0000, 1'b0, "gap2");
    step(1'b0, 32'h3FC00000, 16'h0000, 1'b0, "gap3");
    step(1'b1, 32'h7FC00000, NAN_OUT,  1'b1, "nan");
    step(1'b1, 32'h7F800000, 16'h7FFF, 1'b1, "pinf");
    step(1'b1, 32'hFF800000, 16'h8000, 1'b1, "minf");
    step(1'b1, 32'h3FE00000, 16'h0002, 1'b0, "p1_75");
    step(1'b1, 32'h3F400000, 16'h0001, 1'b0, "p0_75");
    step(1'b1, 32'hBFC00000, 16'hFFFE, 1'b0, "m1_5");
    step(1'b1, 32'h46FFFE00, 16'h7FFF, 1'b0, "p32767");
    step(1'b1, 32'h46FFFF00, 16'h7FFF, 1'b1, "p32767_5");
    step(1'b1, 32'hC7000080, 16'h8000, 1'b0, "m32768_5");
    step(1'b0, 32'h0, 16'h0, 1'b0, "flush1");
    step(1'b0, 32'h0, 16'h0, 1'b0, "flush2");

    // Random stream: 20 valid floats with din_valid toggling randomly.
    n = 0;
    for (int i = 0; i < 200 && n < 20; i++) begin
      f = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 146)), 23'($urandom)};
      case ($urandom_range(0, 15))
        0: f[30:23] = 8'd0;
        1: f[30:23] = 8'd255;
        default: ;
      endcase
      if ($urandom_range(0, 2) != 0) begin
        r = ref_conv(f);
        step(1'b1, f, r[15:0], r[16], "rand");
        n++;
      end else begin
        step(1'b0, f, 16'h0, 1'b0, "rand_gap");
      end
    end
    check("rand_count", 32'(n), 32'd20);
    step(1'b0, 32'h0, 16'h0, 1'b0, "flush3");
    step(1'b0, 32'h0, 16'h0, 1'b0, "flush4");

    // Mid-operation reset: inputs that are in flight must vanish.
    step(1'b1, 32'h3FC00000, 16'h0002, 1'b0, "pre_rst1");
    step(1'b1, 32'h40600000, 16'h0004, 1'b0, "pre_rst2");
    din       = 32'h40200000;
    din_valid = 1'b1;
    nrst      = 1'b0;
    #1;
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    exp_q.delete();
    tag_q.delete();
    last_dout = 16'h0;
    @(posedge clk);
    @(negedge clk);
    check("inrst_valid", 32'(dout_valid), 32'd0);
    nrst      = 1'b1;
    din_valid = 1'b0;
    step(1'b0, 32'h0, 16'h0, 1'b0, "post_rst_idle1");
    step(1'b0, 32'h0, 16'h0, 1'b0, "post_rst_idle2");
    step(1'b0, 32'h0, 16'h0, 1'b0, "post_rst_idle3");
    step(1'b1, 32'h40600000, 16'h0004, 1'b0, "post_rst_in");
    step(1'b0, 32'h0, 16'h0, 1'b0, "post_rst_idle4");
    step(1'b0, 32'h0, 16'h0, 1'b0, "post_rst_idle5");
    step(1'b0, 32'h0, 16'h0, 1'b0, "post_rst_idle6");

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
